// File: rtl/sample_writer_if.sv
// Sample input stream: (x, y) pairs with an end-of-dataset marker.
// A transfer happens on a clk edge where in_valid and in_ready are both high.
interface sample_writer_if #(
    parameter int WIDTH = 20
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             in_last;

    modport master (output in_valid, output in_x, output in_y, output in_last, input in_ready);
    modport slave  (input in_valid, input in_x, input in_y, input in_last, output in_ready);
endinterface

// File: rtl/sample_writer.sv
// Stores an (x, y) sample stream into a frozen dataset memory.
// A registered read port serves the loader.
module sample_writer #(
    parameter int WIDTH  = 20,
    parameter int DEPTH  = 150,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    sample_writer_if.slave    s_in,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_x,
    output logic [WIDTH-1:0]  rd_y,
    output logic [ADDR_W-1:0] count,
    output logic              busy,
    output logic              done,
    output logic [1:0]        o_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_count;
    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  r_rd_x;
    logic [WIDTH-1:0]  r_rd_y;
    logic [WIDTH-1:0]  r_mem_x [0:DEPTH-1];
    logic [WIDTH-1:0]  r_mem_y [0:DEPTH-1];

    logic              w_ready;
    logic              w_accept;
    logic              w_final;

    assign w_ready  = (r_state == LOAD);
    // start outranks a concurrent sample, which is then dropped.
    assign w_accept = rst & s_in.in_valid & w_ready & ~start;
    assign w_final  = s_in.in_last | (r_count == ADDR_W'(DEPTH - 1));

    assign s_in.in_ready = w_ready;
    assign count         = r_count;
    assign busy          = r_busy;
    assign done          = r_done;
    assign rd_x          = r_rd_x;
    assign rd_y          = r_rd_y;
    assign o_state       = r_state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (start) begin
                        r_count <= '0;
                    end else if (w_accept) begin
                        r_count <= r_count + ADDR_W'(1);
                        if (w_final) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Memory has no reset so abandoned data survives a reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem_x[r_count] <= s_in.in_x;
            r_mem_y[r_count] <= s_in.in_y;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_x <= '0;
            r_rd_y <= '0;
        end else if (rd_addr < ADDR_W'(DEPTH)) begin
            r_rd_x <= r_mem_x[rd_addr];
            r_rd_y <= r_mem_y[rd_addr];
        end else begin
            r_rd_x <= '0;
            r_rd_y <= '0;
        end
    end
endmodule

// File: tb/tb_sample_writer.sv
// Directed bench for sample_writer: status checks inline, read data via
// an expected queue drained by a monitor one cycle after each read request.
module tb_sample_writer;
    localparam int W  = 20;
    localparam int D  = 150;
    localparam int AW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_x;
    logic [W-1:0]  rd_y;
    logic [AW-1:0] count;
    logic          busy;
    logic          done;
    logic [1:0]    o_state;

    sample_writer_if #(.WIDTH(W)) s_if ();

    sample_writer #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .s_in    (s_if.slave),
        .rd_addr (rd_addr),
        .rd_x    (rd_x),
        .rd_y    (rd_y),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .o_state (o_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] exp_q[$];
    logic           rd_req;
    logic           rd_req_d;

    always @(posedge clk) rd_req_d <= rd_req;

    // monitor: read data is valid one cycle after a request
    always @(negedge clk) begin
        if (rd_req_d) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected act=%0h/%0h exp=none", rd_x, rd_y);
            end else begin
                logic [2*W-1:0] e;
                e = exp_q.pop_front();
                if ({rd_x, rd_y} !== e) begin
                    errors++;
                    $display("FAIL rd_data act=%0d/%0d exp=%0d/%0d",
                             rd_x, rd_y, e[2*W-1:W], e[W-1:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic last);
        s_if.in_valid = 1'b1;
        s_if.in_x     = x;
        s_if.in_y     = y;
        s_if.in_last  = last;
        cyc();
        s_if.in_valid = 1'b0;
        s_if.in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] ex, input logic [W-1:0] ey);
        rd_addr = a;
        rd_req  = 1'b1;
        exp_q.push_back({ex, ey});
        cyc();
        rd_req  = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; rd_addr = '0; rd_req = 1'b0;
        s_if.in_valid = 1'b0; s_if.in_x = '0; s_if.in_y = '0; s_if.in_last = 1'b0;
        cyc(); cyc();

        // reset state
        chk("rst_state", o_state, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", s_if.in_ready, 0);
        chk("rst_rdx", rd_x, 0);
        chk("rst_rdy", rd_y, 0);
        rst = 1'b1;
        cyc();
        chk("idle_ready", s_if.in_ready, 0);

        // basic 3-sample dataset with in_last
        pulse_start();
        chk("ld_busy", busy, 1);
        chk("ld_ready", s_if.in_ready, 1);
        chk("ld_count0", count, 0);
        send(1, 10, 0);
        send(2, 20, 0);
        send(3, 30, 1);
        chk("t1_count", count, 3);
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_ready", s_if.in_ready, 0);
        chk("t1_state", o_state, 2);
        rd(0, 1, 10);
        rd(1, 2, 20);
        rd(2, 3, 30);
        rd(200, 0, 0);
        cyc();

        // full memory, no in_last
        pulse_start();
        for (int i = 0; i < D; i++) begin
            if (i == D - 1) chk("full_busy_149", busy, 1);
            send(W'(100 + i), W'(1000 + i), 0);
        end
        chk("full_count", count, 150);
        chk("full_done", done, 1);
        chk("full_ready", s_if.in_ready, 0);
        send(20'hABCDE, 20'h12345, 0);
        chk("full_count_hold", count, 150);
        rd(149, 249, 1149);
        rd(0, 100, 1000);
        cyc();

        // valid gaps, in_last without valid ignored
        pulse_start();
        send(5, 50, 0);
        s_if.in_x = 6; s_if.in_y = 60; s_if.in_last = 1'b1;
        cyc();
        s_if.in_last = 1'b0;
        send(7, 70, 0);
        send(8, 80, 0);
        chk("gap_count", count, 3);
        chk("gap_busy", busy, 1);
        rd(0, 5, 50);
        rd(1, 7, 70);
        rd(2, 8, 80);
        cyc();

        // restart in LOAD with a concurrent sample, then read-first write
        pulse_start();
        send(4, 40, 0);
        send(11, 41, 0);
        send(12, 42, 0);
        send(13, 43, 0);
        chk("pre_rs_count", count, 4);
        start = 1'b1;
        send(99, 99, 0);
        start = 1'b0;
        chk("rs_count", count, 0);
        chk("rs_state", o_state, 1);
        s_if.in_valid = 1'b1; s_if.in_x = 7; s_if.in_y = 77;
        rd(0, 4, 40);
        s_if.in_valid = 1'b0;
        rd(0, 7, 77);
        chk("rs_count1", count, 1);
        rd(1, 11, 41);
        cyc();

        // reset mid-LOAD
        pulse_start();
        for (int i = 0; i < 5; i++) send(W'(i + 60), W'(i + 600), 0);
        chk("mid_count", count, 5);
        rst = 1'b0;
        cyc();
        chk("mrst_state", o_state, 0);
        chk("mrst_count", count, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", s_if.in_ready, 0);
        chk("mrst_rdx", rd_x, 0);
        chk("mrst_rdy", rd_y, 0);
        rst = 1'b1;
        cyc();
        chk("mrst_idle_ready", s_if.in_ready, 0);
        rd(4, 64, 604);
        pulse_start();
        chk("mrst_restart_ready", s_if.in_ready, 1);
        cyc();

        chk("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sample_writer.md
Name: sample_writer

Overview:
- Write-side counterpart to the regression data loader: accepts (x, y) sample pairs over a valid/ready stream and stores them in an internal sample memory.
- The loader side reads the memory through a registered read port.
- A small FSM controls loading: idle, then fill, then a frozen dataset.
- It reports the stored sample count, so the controller knows where the loader's counter must stop.

Parameters:
WIDTH, 20, bit width of each x and y sample
DEPTH, 150, number of sample slots in the memory
ADDR_W, 8, address and count width; must satisfy 2^ADDR_W > DEPTH

Ports:
clk  input  1  clock; all state changes on its rising edge
rst  input  1  synchronous active-low reset; sampled on the clk rising edge, 0 = reset
start  input  1  one-cycle pulse: clear count and begin accepting samples
in_valid  input  1  producer holds a valid sample on in_x/in_y
in_ready  output  1  block can accept a sample this cycle
in_x  input  WIDTH  x sample
in_y  input  WIDTH  y sample
in_last  input  1  qualifies the accepted sample as the final one of the dataset
rd_addr  input  ADDR_W  read address from the loader
rd_x  output  WIDTH  registered x at rd_addr, one-cycle latency
rd_y  output  WIDTH  registered y at rd_addr, one-cycle latency
count  output  ADDR_W  number of samples stored since the last start
busy  output  1  high while in LOAD
done  output  1  high while in DONE (dataset complete and frozen)

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; count=0; rd_x=0; rd_y=0; busy=0; done=0.
  - Memory contents are not cleared.
- States:
  - IDLE: in_ready=0. start -> LOAD with count=0.
  - LOAD: in_ready=1; busy=1.
  - DONE: in_ready=0; done=1. start -> LOAD with count=0.
- Accept rule: a sample is accepted when in_valid & in_ready at a clk edge.
  - On accept: mem_x[count]<=in_x, mem_y[count]<=in_y, count<=count+1.
- in_ready is decoded combinationally from the state only. It never depends on in_valid.
- LOAD -> DONE on the accept edge when either condition holds:
  - in_last=1, or
  - count==DEPTH-1 (memory full).
  - in_ready therefore drops in the cycle after the final accept. A full memory is never overwritten.
- in_valid without in_ready: ignored. Data is not captured and count is unchanged.
- start while in LOAD: restarts. count<=0, state stays LOAD. Any sample presented in that same cycle is dropped (start has priority).
- start in the same cycle as a terminating accept: start wins. count<=0, state=LOAD, and that sample is dropped.
- in_last with no accept (in_valid=0): no effect.
- Read port:
  - rd_x/rd_y <= mem[rd_addr] every cycle, in every state (1-cycle latency).
  - If rd_addr equals the address being written in the same cycle, the read returns the old contents (read-first).
  - rd_addr >= DEPTH returns 0.
- Reset mid-LOAD: returns to IDLE with count=0. Partial data is abandoned but stays in memory.
- count saturates at DEPTH and never wraps.

Test Plan:
- Reset, start, then 3 samples (x=1..3, y=10,20,30) with in_last on the third -> count=3; done=1 the cycle after the third accept; in_ready=0; reading addr 0..2 gives (1,10),(2,20),(3,30) with 1-cycle latency.
- Start, then DEPTH=150 back-to-back samples with in_last=0 -> DONE after the 150th accept; count=150; a 151st in_valid is not accepted and mem[149] is unchanged.
- In LOAD, toggle in_valid 1,0,1,1 with data 5,6,7,8 -> only 5,7,8 are stored at addresses 0..2; count=3.
- After loading 4 samples, pulse start together with in_valid (x=99) -> count=0, state LOAD, 99 not stored; the next accepted sample lands at address 0.
- Write address 0 with x=7 while rd_addr=0 holds the old value 4 -> rd_x=4 the next cycle, then 7 the cycle after.
- Assert rst=0 mid-LOAD at count=5 -> next cycle state IDLE, count=0, busy=0, in_ready=0, rd_x=rd_y=0; start is required before in_ready rises again.
